// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: owns the PC, runs the imem req/ack handshake,
// applies taken-branch redirects with a flush pulse and bubble countdown.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resolve_valid,
    input  logic             branch,
    input  logic             zero_flag,
    input  logic [31:0]      branch_target,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic [3:0]       BUB_INIT = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_drain_addr;
    logic [3:0]       r_bub;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic             r_flush;
    logic [CNT_W-1:0] r_cnt;

    logic             w_taken;
    logic [31:0]      w_target;

    assign w_taken  = resolve_valid & branch & zero_flag & (r_state != S_IDLE);
    assign w_target = {branch_target[31:2], 2'b00};

    // Request/address come only from registered state; DRAIN keeps presenting
    // the abandoned address because the PC has already moved to the target.
    assign imem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign flush       = r_flush;
    assign taken_cnt   = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_bub        <= 4'd0;
            r_instr      <= 32'd0;
            r_valid      <= 1'b0;
            r_flush      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            if (w_taken) begin
                r_pc    <= w_target;
                r_flush <= 1'b1;
                if (!(&r_cnt))
                    r_cnt <= r_cnt + CNT_ONE;
            end
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_taken) begin
                        if (imem_ack) begin
                            r_state <= S_FLUSH;
                            r_bub   <= BUB_INIT;
                        end else begin
                            r_state      <= S_DRAIN;
                            r_drain_addr <= r_pc;
                        end
                    end else if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= stall ? S_HOLD : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (w_taken) begin
                        r_state <= S_FLUSH;
                        r_bub   <= BUB_INIT;
                    end else if (!stall) begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_state <= S_FLUSH;
                        r_bub   <= BUB_INIT;
                    end
                end
                S_FLUSH: begin
                    if (w_taken)
                        r_bub <= BUB_INIT;
                    else if (r_bub == 4'd1)
                        r_state <= stall ? S_HOLD : S_REQ;
                    else
                        r_bub <= r_bub - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: two configurations driven together and
// compared every cycle against a request/bubble-level reference model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rv, br, zf, stall, ack;
    logic [31:0] tgt;
    logic        req0, req1, iv0, iv1, fl0, fl1;
    logic [31:0] addr0, addr1, rd0, rd1, io0, io1;
    logic [15:0] tc0;
    logic [1:0]  tc1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign rd0 = mem(addr0);
    assign rd1 = mem(addr1);

    pc_sequencer dut0 (
        .clk(clk), .rst(rst), .resolve_valid(rv), .branch(br), .zero_flag(zf),
        .branch_target(tgt), .stall(stall), .imem_req(req0), .imem_addr(addr0),
        .imem_ack(ack), .imem_rdata(rd0), .instr_out(io0), .instr_valid(iv0),
        .flush(fl0), .taken_cnt(tc0)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF0), .FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .resolve_valid(rv), .branch(br), .zero_flag(zf),
        .branch_target(tgt), .stall(stall), .imem_req(req1), .imem_addr(addr1),
        .imem_ack(ack), .imem_rdata(rd1), .instr_out(io1), .instr_valid(iv1),
        .flush(fl1), .taken_cnt(tc1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Model tracks whether a request is outstanding, whether its response is
    // to be thrown away, and how many bubbles remain before fetching resumes.
    typedef struct packed {
        logic        started, outst, discard, ival, fl;
        logic [31:0] bub, pc, raddr, iout, cnt;
    } mdl_t;

    mdl_t m0, m1;
    bit   dir_done;

    function automatic mdl_t mreset(input logic [31:0] pc);
        mdl_t m;
        m    = '0;
        m.pc = pc;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int fc, input int cmax, input bit tk,
                                  input logic [31:0] t, input bit st, input bit ak);
        mdl_t o;
        o      = m;
        o.ival = 1'b0;
        o.fl   = 1'b0;
        if (!m.started) begin
            o.started = 1'b1;
            o.outst   = 1'b1;
            o.raddr   = m.pc;
        end else if (tk) begin
            o.pc = {t[31:2], 2'b00};
            o.fl = 1'b1;
            if (m.cnt < 32'(cmax)) o.cnt = m.cnt + 1;
            if (m.outst && !ak) begin
                o.discard = 1'b1;
            end else begin
                o.outst   = 1'b0;
                o.discard = 1'b0;
                o.bub     = 32'(fc);
            end
        end else if (m.outst && ak) begin
            o.outst = 1'b0;
            if (m.discard) begin
                o.discard = 1'b0;
                o.bub     = 32'(fc);
            end else begin
                o.iout = mem(m.raddr);
                o.ival = 1'b1;
                o.pc   = m.pc + 32'd4;
                if (!st) begin
                    o.outst = 1'b1;
                    o.raddr = m.pc + 32'd4;
                end
            end
        end else if (!m.outst) begin
            if (m.bub > 1) begin
                o.bub = m.bub - 1;
            end else begin
                o.bub = 0;
                if (!st) begin
                    o.outst = 1'b1;
                    o.raddr = m.pc;
                end
            end
        end
        return o;
    endfunction

    task automatic check_all();
        chk("req0", 32'(req0), 32'(m0.outst));
        if (m0.outst) chk("addr0", addr0, m0.raddr);
        chk("valid0", 32'(iv0), 32'(m0.ival));
        chk("instr0", io0, m0.iout);
        chk("flush0", 32'(fl0), 32'(m0.fl));
        chk("cnt0", 32'(tc0), m0.cnt);
        chk("req1", 32'(req1), 32'(m1.outst));
        if (m1.outst) chk("addr1", addr1, m1.raddr);
        chk("valid1", 32'(iv1), 32'(m1.ival));
        chk("instr1", io1, m1.iout);
        chk("flush1", 32'(fl1), 32'(m1.fl));
        chk("cnt1", 32'(tc1), m1.cnt);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req0"}, 32'(req0), 32'd0);
        chk({tag, "_req1"}, 32'(req1), 32'd0);
        chk({tag, "_addr0"}, addr0, 32'h0000_0000);
        chk({tag, "_addr1"}, addr1, 32'hFFFF_FFF0);
        chk({tag, "_valid0"}, 32'(iv0), 32'd0);
        chk({tag, "_instr0"}, io0, 32'd0);
        chk({tag, "_flush0"}, 32'(fl0), 32'd0);
        chk({tag, "_cnt0"}, 32'(tc0), 32'd0);
        chk({tag, "_cnt1"}, 32'(tc1), 32'd0);
    endtask

    // Called at a negedge: drive inputs, advance models, then check after the edge.
    task automatic cyc(input int mode);
        bit tk;
        case (mode)
            0: begin
                ack = 1'b1; stall = 1'b0; rv = 1'b0; br = 1'b0; zf = 1'b0; tgt = 32'd0;
                if (!dir_done && req0 && addr0 == 32'h10) begin
                    rv = 1'b1; br = 1'b1; zf = 1'b1; tgt = 32'h0000_0103;
                    dir_done = 1'b1;
                end
            end
            default: begin
                ack   = ($urandom_range(0, 2) != 0);
                stall = ($urandom_range(0, 3) == 0);
                rv    = ($urandom_range(0, 9) < (mode == 2 ? 7 : 3));
                br    = ($urandom_range(0, 3) != 0);
                zf    = ($urandom_range(0, 1) == 1);
                tgt   = $urandom;
            end
        endcase
        tk = rv & br & zf;
        m0 = step(m0, 1, 65535, tk, tgt, stall, ack);
        m1 = step(m1, 3, 3, tk, tgt, stall, ack);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; br = 1'b0; zf = 1'b0; stall = 1'b0; ack = 1'b0; tgt = 32'd0;
        dir_done = 1'b0;
        @(negedge clk);
        check_reset("rst");
        m0  = mreset(32'h0000_0000);
        m1  = mreset(32'hFFFF_FFF0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) cyc(0);
        for (int i = 0; i < 400; i++) cyc(1);

        // Reset asserted between edges must drop any request immediately.
        ack = 1'b0; rv = 1'b0; stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_req0", 32'(req0), 32'd0);
        chk("midrst_req1", 32'(req1), 32'd0);
        ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst2");
        m0  = mreset(32'h0000_0000);
        m1  = mreset(32'hFFFF_FFF0);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) cyc(2);
        for (int i = 0; i < 300; i++) cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
